// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory responder.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DUMMY   = 3'd5,
    ST_IGNORE  = 3'd6
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int ADDR_W     = 24;
  localparam int ADDR_BYTES = ADDR_W / 8;

endpackage

// File: rtl/spi_mem_responder_edge_sync.sv
// Synchronizes the SPI pins into clk and flags synced SCLK rise/fall;
// mosi and cs_n see the same pipeline depth so they stay aligned to sclk.
module spi_edge_sync
  import spi_mem_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_sync,
  output logic cs_n_sync
);

  logic [SYNC_STAGES-1:0] sclk_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic [SYNC_STAGES-1:0] cs_pipe_r;
  logic                   sclk_d_r;

  // cs_n resets to "selected" so the top only arms after a genuine high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe_r <= {SYNC_STAGES{1'b0}};
      mosi_pipe_r <= {SYNC_STAGES{1'b0}};
      cs_pipe_r   <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
    end else begin
      sclk_pipe_r <= {sclk_pipe_r[SYNC_STAGES-2:0], sclk};
      mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], mosi};
      cs_pipe_r   <= {cs_pipe_r[SYNC_STAGES-2:0], cs_n};
      sclk_d_r    <= sclk_pipe_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_pipe_r[SYNC_STAGES-1] & ~sclk_d_r;
  assign sclk_fall = ~sclk_pipe_r[SYNC_STAGES-1] & sclk_d_r;
  assign mosi_sync = mosi_pipe_r[SYNC_STAGES-1];
  assign cs_n_sync = cs_pipe_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target answering READ/WRITE with a 24-bit address.
// Define SPI_MEM_FASTREAD_EN to accept FAST READ (0x0B) with 8 dummy clocks.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic sclk_rise_s, sclk_fall_s, mosi_sync_s, cs_n_sync_s;
  state_e state_r, state_next_s;
  logic armed_r;
  logic [2:0] bit_cnt_r;
  logic [1:0] addr_cnt_r;
  logic [6:0] shift_in_r;
  logic [7:0] cmd_r;
  logic [7:0] shift_out_r;
  logic [ADDR_BITS-1:0] mem_addr_r;
  logic [7:0] mem_r [DEPTH];
  logic miso_r, miso_oe_r, busy_r, cmd_err_r;
  logic miso_s, miso_oe_s, busy_s, cmd_err_s;
  logic [7:0] byte_val_s;
  logic byte_done_s, last_addr_byte_s;
  logic [ADDR_BITS-1:0] addr_next_s, mem_addr_inc_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .mosi_sync (mosi_sync_s),
    .cs_n_sync (cs_n_sync_s)
  );

  function automatic logic cmd_supported(input logic [7:0] cmd);
`ifdef SPI_MEM_FASTREAD_EN
    return (cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_FAST_READ);
`else
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
`endif
  endfunction

  // A deasserting cs_n masks the coinciding rise, so a partial byte never completes.
  assign byte_val_s       = {shift_in_r, mosi_sync_s};
  assign byte_done_s      = sclk_rise_s && (bit_cnt_r == 3'd7) && !cs_n_sync_s;
  assign addr_next_s      = ADDR_BITS'({mem_addr_r, byte_val_s});
  assign mem_addr_inc_s   = mem_addr_r + ADDR_BITS'(1);
  assign last_addr_byte_s = (state_r == ST_ADDR) && byte_done_s &&
                            (addr_cnt_r == 2'(ADDR_BYTES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (cs_n_sync_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (armed_r) state_next_s = ST_CMD;
          else         state_next_s = ST_IDLE;
        end
        ST_CMD: begin
          if (byte_done_s) state_next_s = cmd_supported(byte_val_s) ? ST_ADDR : ST_IGNORE;
          else             state_next_s = ST_CMD;
        end
        ST_ADDR: begin
          if (last_addr_byte_s) begin
            case (cmd_r)
              CMD_WRITE:     state_next_s = ST_WR_DATA;
`ifdef SPI_MEM_FASTREAD_EN
              CMD_FAST_READ: state_next_s = ST_DUMMY;
`endif
              default:       state_next_s = ST_RD_DATA;
            endcase
          end else begin
            state_next_s = ST_ADDR;
          end
        end
        ST_DUMMY: begin
          if (byte_done_s) state_next_s = ST_RD_DATA;
          else             state_next_s = ST_DUMMY;
        end
        default: state_next_s = state_r;
      endcase
    end
  end

  // Output logic: what the registered outputs take next cycle.
  always_comb begin
    miso_s    = miso_r;
    miso_oe_s = miso_oe_r;
    if (cs_n_sync_s || (state_r != ST_RD_DATA)) begin
      miso_s    = 1'b0;
      miso_oe_s = 1'b0;
    end else if (sclk_fall_s) begin
      miso_s    = shift_out_r[7];
      miso_oe_s = 1'b1;
    end else begin
      miso_s    = miso_r;
      miso_oe_s = miso_oe_r;
    end
    cmd_err_s = (state_r == ST_CMD) && byte_done_s && !cmd_supported(byte_val_s);
    busy_s    = !cs_n_sync_s && armed_r;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r    <= 1'b0;
      miso_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      miso_r    <= miso_s;
      miso_oe_r <= miso_oe_s;
      busy_r    <= busy_s;
      cmd_err_r <= cmd_err_s;
    end
  end

  // Bit/byte counters, command capture, address and shift-out datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r     <= 1'b0;
      bit_cnt_r   <= 3'd0;
      addr_cnt_r  <= 2'd0;
      shift_in_r  <= 7'd0;
      cmd_r       <= 8'd0;
      mem_addr_r  <= {ADDR_BITS{1'b0}};
      shift_out_r <= 8'd0;
    end else begin
      armed_r <= armed_r | cs_n_sync_s;
      if ((state_r == ST_IDLE) || cs_n_sync_s) begin
        bit_cnt_r  <= 3'd0;
        addr_cnt_r <= 2'd0;
      end else if (sclk_rise_s) begin
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        shift_in_r <= byte_val_s[6:0];
        if ((state_r == ST_ADDR) && byte_done_s) addr_cnt_r <= addr_cnt_r + 2'd1;
      end
      if ((state_r == ST_CMD) && byte_done_s) cmd_r <= byte_val_s;
      if ((state_r == ST_ADDR) && byte_done_s) begin
        mem_addr_r <= addr_next_s;
      end else if (((state_r == ST_RD_DATA) || (state_r == ST_WR_DATA)) && byte_done_s) begin
        mem_addr_r <= mem_addr_inc_s;
      end
      if (last_addr_byte_s) begin
        shift_out_r <= mem_r[addr_next_s];
      end else if ((state_r == ST_DUMMY) && byte_done_s) begin
        shift_out_r <= mem_r[mem_addr_r];
      end else if ((state_r == ST_RD_DATA) && byte_done_s) begin
        shift_out_r <= mem_r[mem_addr_inc_s];
      end else if ((state_r == ST_RD_DATA) && sclk_fall_s && !cs_n_sync_s) begin
        shift_out_r <= {shift_out_r[6:0], 1'b0};
      end
    end
  end

  // Byte array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_WR_DATA) && byte_done_s) mem_r[mem_addr_r] <= byte_val_s;
  end

  assign miso    = miso_r;
  assign miso_oe = miso_oe_r;
  assign busy    = busy_r;
  assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed self-checking bench for spi_mem_responder (SCLK = clk / 8).
module tb_spi_mem_responder;

  logic clk = 1'b0;
  logic rst_n, sclk, mosi, cs_n;
  logic miso, miso_oe, busy, cmd_err;

  int n_checks = 0;
  int n_fails  = 0;
  int err_cnt  = 0;
  int oe_cnt   = 0;
  int err_base, oe_base;
  logic [7:0] rd_buf [4];
  logic [7:0] dummy;

  spi_mem_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .miso    (miso),
    .miso_oe (miso_oe),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (miso_oe) oe_cnt  <= oe_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx MSB-first; miso sampled just before each rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      #39;
      rx[i] = miso;
      #1;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    xfer(cmd, 8, d);
    xfer(addr[23:16], 8, d);
    xfer(addr[15:8], 8, d);
    xfer(addr[7:0], 8, d);
  endtask

  task automatic write_bytes(input logic [23:0] addr, input logic [31:0] data, input int n);
    logic [7:0] d;
    cs_begin();
    send_hdr(8'h02, addr);
    check_val("busy_wr", {31'd0, busy}, 32'd1);
    for (int k = 0; k < n; k++) xfer(data[31 - 8*k -: 8], 8, d);
    cs_end();
  endtask

  task automatic read_bytes(input logic [23:0] addr, input int n);
    cs_begin();
    send_hdr(8'h03, addr);
    check_val("busy_rd", {31'd0, busy}, 32'd1);
    for (int k = 0; k < n; k++) xfer(8'h00, 8, rd_buf[k]);
    cs_end();
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    #20;
    check_val("rst_miso", {31'd0, miso}, 32'd0);
    check_val("rst_oe", {31'd0, miso_oe}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    #20;
    rst_n = 1'b1;
    #100;

    // Write then burst read back.
    err_base = err_cnt;
    write_bytes(24'h000010, 32'hDEADBEEF, 4);
    check_val("busy_idle", {31'd0, busy}, 32'd0);
    read_bytes(24'h000010, 4);
    check_val("rd0", {24'd0, rd_buf[0]}, 32'hDE);
    check_val("rd1", {24'd0, rd_buf[1]}, 32'hAD);
    check_val("rd2", {24'd0, rd_buf[2]}, 32'hBE);
    check_val("rd3", {24'd0, rd_buf[3]}, 32'hEF);
    check_val("no_err_rw", err_cnt - err_base, 32'd0);

    // Address wrap and aliasing of high address bits.
    write_bytes(24'h0000FF, 32'h11220000, 2);
    read_bytes(24'h000000, 1);
    check_val("wrap_lo", {24'd0, rd_buf[0]}, 32'h22);
    read_bytes(24'h0000FF, 1);
    check_val("wrap_hi", {24'd0, rd_buf[0]}, 32'h11);
    read_bytes(24'hAB0110, 1);
    check_val("alias", {24'd0, rd_buf[0]}, 32'hDE);

    // Unsupported command.
    err_base = err_cnt;
    oe_base  = oe_cnt;
    cs_begin();
    xfer(8'h9F, 8, dummy);
    check_val("bad_cmd_err", err_cnt - err_base, 32'd1);
    for (int k = 0; k < 4; k++) xfer(8'h03, 8, dummy);
    check_val("ignore_oe", oe_cnt - oe_base, 32'd0);
    check_val("ignore_err", err_cnt - err_base, 32'd1);
    cs_end();
    read_bytes(24'h000010, 1);
    check_val("rd_after_bad", {24'd0, rd_buf[0]}, 32'hDE);

    // Aborted write byte is not committed.
    write_bytes(24'h000020, 32'h55000000, 1);
    cs_begin();
    send_hdr(8'h02, 24'h000020);
    xfer(8'hAA, 3, dummy);
    cs_end();
    read_bytes(24'h000020, 1);
    check_val("partial_wr", {24'd0, rd_buf[0]}, 32'h55);

    // Reset in the middle of a read (bit 3 of 0xDE is 1).
    cs_begin();
    send_hdr(8'h03, 24'h000010);
    xfer(8'h00, 4, dummy);
    #30;
    check_val("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
    check_val("pre_rst_miso", {31'd0, miso}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_oe", {31'd0, miso_oe}, 32'd0);
    check_val("async_rst_miso", {31'd0, miso}, 32'd0);
    #9;
    rst_n = 1'b1;
    #40;
    err_base = err_cnt;
    oe_base  = oe_cnt;
    xfer(8'h9F, 8, dummy);
    xfer(8'h03, 8, dummy);
    check_val("post_rst_oe", oe_cnt - oe_base, 32'd0);
    check_val("post_rst_err", err_cnt - err_base, 32'd0);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);
    cs_end();
    write_bytes(24'h000040, 32'h3C000000, 1);
    read_bytes(24'h000040, 1);
    check_val("rd_after_rst", {24'd0, rd_buf[0]}, 32'h3C);

    // FAST READ: supported only with the option enabled.
    write_bytes(24'h000010, 32'hDE000000, 1);
    err_base = err_cnt;
    cs_begin();
    send_hdr(8'h0B, 24'h000010);
`ifdef SPI_MEM_FASTREAD_EN
    oe_base = oe_cnt;
    xfer(8'h00, 8, dummy);
    check_val("fast_dummy_oe", oe_cnt - oe_base, 32'd0);
    xfer(8'h00, 8, rd_buf[0]);
    check_val("fast_rd", {24'd0, rd_buf[0]}, 32'hDE);
    check_val("fast_no_err", err_cnt - err_base, 32'd0);
`else
    check_val("fast_unsupported", err_cnt - err_base, 32'd1);
`endif
    cs_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
